apb_protocol: RTL and testbench
===============================

# apb_protocol

Self-contained APB subsystem: an APB master FSM converts a simple transfer request (Transfer, Wr_Rd, Address, write_data) into APB SETUP/ACCESS phases. The phases drive an internal zero-wait-state APB slave backed by a word-addressed register memory. The block serves as a bus-protocol demonstrator and verification target. Read results return on read_data.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write_data/read_data and memory words
- ADDR_WIDTH, 32, width of Address
- MEM_DEPTH, 64, number of slave memory words (power of two)

Ports:
- PCLK  in  1  single clock, all state updates on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- Transfer  in  1  request: high = perform/continue transfers
- Wr_Rd  in  1  1 = write, 0 = read
- Address  in  ADDR_WIDTH  word address of the transfer
- write_data  in  DATA_WIDTH  data for write transfers
- read_data  out  DATA_WIDTH  data returned by the most recent completed read

## Operation
- Internal APB signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY. The slave ties PREADY = 1.
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE: PSEL = 0, PENABLE = 0. Moves to SETUP when Transfer = 1; otherwise stays.
  - SETUP: PSEL = 1, PENABLE = 0. Always moves to ACCESS next.
  - ACCESS: PSEL = 1, PENABLE = 1. When PREADY = 1: moves to SETUP if Transfer = 1 (back-to-back), else IDLE. When PREADY = 0: stays.
- PADDR, PWRITE and PWDATA are registered from Address, Wr_Rd and write_data on every edge that enters SETUP. They are held constant through ACCESS.
- Slave write: on an edge where PSEL & PENABLE & PWRITE hold, mem[PADDR mod MEM_DEPTH] <= PWDATA.
- Slave read: PRDATA = mem[PADDR mod MEM_DEPTH], combinational.
- Master read: on an edge where PSEL & PENABLE & !PWRITE & PREADY hold, read_data <= PRDATA. Otherwise read_data holds its value.
- Address wrap: only Address[log2(MEM_DEPTH)-1:0] is decoded. Upper bits are ignored, so addresses alias modulo MEM_DEPTH. There is no error response.
- Changes on Address, Wr_Rd or write_data during ACCESS do not affect the current transfer.
- Deasserting Transfer during SETUP or ACCESS does not abort the transfer. The transfer completes, then the FSM goes to IDLE.

## Timing
- Reset (asynchronous assertion) puts the block in the following state:
  - FSM in IDLE
  - PSEL = PENABLE = PWRITE = 0; PADDR = PWDATA = 0
  - read_data = 0
  - all memory words = 0
- Reset asserted mid-transfer: the transfer is abandoned and no memory write occurs on that edge. After reset release, the FSM restarts from IDLE on the first edge with Transfer = 1.
- Latency: Transfer = 1 sampled at edge N gives the following sequence:
  - SETUP during cycle N..N+1
  - ACCESS during cycle N+1..N+2
  - write committed, or read_data valid, at edge N+2
- Back-to-back throughput with Transfer held high: one transfer per 2 cycles, with SETUP re-entered directly from ACCESS.
- A write followed immediately by a read of the same address returns the newly written data.

## Structure
- Shared package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS}
  - default DATA_WIDTH, ADDR_WIDTH and MEM_DEPTH constants
- Sub-module apb_slave_mem implements the memory, the write port, the PRDATA mux and PREADY.
- The top level contains the master FSM and the phase registers, and instantiates apb_slave_mem.

## Test plan
- Reset: hold PRESETn = 0 → read_data = 0 and FSM in IDLE. Release, then read address 5 → read_data = 0x00000000.
- Writes then reads: write 0xABCDABCD to address 0 and 0xCAFECAFE to address 1, then read address 1 → 0xCAFECAFE, then read address 0 → 0xABCDABCD. Each read_data update occurs exactly 2 edges after the request is sampled.
- Sweep: for i = 0..9, write 0xABCDABCD to address i and 0xCAFECAFE to address i+1, with Transfer pulsed low between phases → the read-back of address i+1 returns 0xCAFECAFE and read_data holds between reads.
- Wrap-around: write 0x12345678 to address 64, then read address 0 → 0x12345678.
- Transfer low in ACCESS: the transfer still completes and the FSM goes to IDLE. Address changed during ACCESS → the write lands at the address latched in SETUP.
- Reset mid-transfer: assert PRESETn = 0 during ACCESS of a write of 0xDEADBEEF to address 3 → a later read of address 3 returns 0x00000000.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB demonstrator subsystem.
//   - apb_state_e : master FSM states
//   - DEFAULT_*   : default bus/memory dimensions used by apb_protocol
package apb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_MEM_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: zero-wait-state APB slave backed by a word-addressed register memory.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (clears every word)
//   i_psel           slave select
//   i_penable        access phase
//   i_pwrite         1 = write, 0 = read
//   i_paddr          decoded word index (already reduced modulo MEM_DEPTH)
//   i_pwdata         write data
//   o_prdata         combinational read data for i_paddr
//   o_pready         always 1 (no wait states)
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [IDX_WIDTH-1:0]  i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_wr_en;

  assign w_wr_en  = i_psel & i_penable & i_pwrite;
  assign o_pready = 1'b1;
  assign o_prdata = r_mem[i_paddr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

endmodule

// File: rtl/apb_protocol.sv
// apb_protocol: APB master FSM turning a simple transfer request into SETUP/ACCESS
// phases against an internal zero-wait-state memory slave.
// Ports:
//   PCLK        clock, all state on rising edge
//   PRESETn     asynchronous active-low reset
//   Transfer    request: high = perform/continue transfers
//   Wr_Rd       1 = write, 0 = read
//   Address     word address (aliases modulo MEM_DEPTH)
//   write_data  data for write transfers
//   read_data   data returned by the most recent completed read
module apb_protocol
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  Transfer,
  input  logic                  Wr_Rd,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned IdxWidth = $clog2(MEM_DEPTH);

  apb_state_e            r_state;
  apb_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  w_psel;
  logic                  w_penable;
  logic                  w_pready;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_unused_paddr_hi;

  // Upper address bits are latched for visibility but never decoded (aliasing).
  assign w_unused_paddr_hi = ^r_paddr[ADDR_WIDTH-1:IdxWidth];

  always_comb begin
    w_state_next = r_state;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Transfer) w_state_next = SETUP;
      end
      SETUP: begin
        w_psel       = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (w_pready) w_state_next = Transfer ? SETUP : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Phase registers capture the request only on entry to SETUP, so request
  // changes during ACCESS cannot disturb the transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_state_next == SETUP) begin
      r_paddr  <= Address;
      r_pwrite <= Wr_Rd;
      r_pwdata <= write_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_read_data <= '0;
    end else if (w_psel && w_penable && !r_pwrite && w_pready) begin
      r_read_data <= w_prdata;
    end
  end

  assign read_data = r_read_data;

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_WIDTH  (IdxWidth)
  ) u_slave (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_psel    (w_psel),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[IdxWidth-1:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata),
    .o_pready  (w_pready)
  );

endmodule

// File: tb/tb_apb_protocol.sv
// tb_apb_protocol: directed bench for apb_protocol with a reference memory model and a
// scoreboard queue of expected read results.
module tb_apb_protocol;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        Transfer;
  logic        Wr_Rd;
  logic [31:0] Address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [64];
  logic [31:0] sb [$];
  logic [31:0] last_read;
  logic [31:0] exp_v;

  apb_protocol dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .Transfer   (Transfer),
    .Wr_Rd      (Wr_Rd),
    .Address    (Address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    last_read = '0;
  endtask

  // Single transfer from IDLE, Transfer dropped after the SETUP edge. Starts and ends at negedge.
  task automatic xfer(input bit wr, input int unsigned addr, input logic [31:0] data);
    Transfer   = 1'b1;
    Wr_Rd      = wr;
    Address    = addr;
    write_data = data;
    if (wr) model_mem[addr % 64] = data;
    else sb.push_back(model_mem[addr % 64]);
    cycle();
    Transfer = 1'b0;
    check("setup_state", 32'(dut.r_state), 32'(SETUP));
    cycle();
    check("access_state", 32'(dut.r_state), 32'(ACCESS));
    check("rd_hold_in_access", read_data, last_read);
    cycle();
    check("idle_after", 32'(dut.r_state), 32'(IDLE));
    if (!wr) begin
      exp_v = sb.pop_front();
      check("rd_data", read_data, exp_v);
      last_read = exp_v;
    end
  endtask

  initial begin
    PRESETn    = 1'b0;
    Transfer   = 1'b0;
    Wr_Rd      = 1'b0;
    Address    = '0;
    write_data = '0;
    clear_model();

    // Reset
    repeat (3) cycle();
    check("rst_read_data", read_data, 32'h0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_psel", 32'(dut.w_psel), 32'h0);
    PRESETn = 1'b1;
    cycle();
    check("idle_hold", 32'(dut.r_state), 32'(IDLE));
    xfer(1'b0, 5, '0);

    // Writes then reads
    xfer(1'b1, 0, 32'hABCDABCD);
    xfer(1'b1, 1, 32'hCAFECAFE);
    xfer(1'b0, 1, '0);
    xfer(1'b0, 0, '0);

    // Sweep with hold check between reads
    for (int i = 0; i < 10; i++) begin
      xfer(1'b1, i, 32'hABCDABCD);
      xfer(1'b1, i + 1, 32'hCAFECAFE);
      xfer(1'b0, i + 1, '0);
      cycle();
      check("sweep_hold", read_data, last_read);
    end

    // Wrap-around
    xfer(1'b1, 64, 32'h12345678);
    xfer(1'b0, 0, '0);
    xfer(1'b0, 32'hFFFF_FFC1, '0);

    // Back-to-back write then read of the same address
    Transfer   = 1'b1;
    Wr_Rd      = 1'b1;
    Address    = 7;
    write_data = 32'h5A5A1234;
    model_mem[7] = 32'h5A5A1234;
    cycle();
    check("b2b_setup1", 32'(dut.r_state), 32'(SETUP));
    cycle();
    check("b2b_access1", 32'(dut.r_state), 32'(ACCESS));
    Wr_Rd   = 1'b0;
    Address = 7;
    sb.push_back(model_mem[7]);
    cycle();
    check("b2b_setup2", 32'(dut.r_state), 32'(SETUP));
    check("b2b_rd_hold", read_data, last_read);
    Transfer = 1'b0;
    cycle();
    check("b2b_access2", 32'(dut.r_state), 32'(ACCESS));
    cycle();
    check("b2b_idle", 32'(dut.r_state), 32'(IDLE));
    exp_v = sb.pop_front();
    check("b2b_rd_data", read_data, exp_v);
    last_read = exp_v;

    // Transfer low and request changed during ACCESS
    Transfer   = 1'b1;
    Wr_Rd      = 1'b1;
    Address    = 9;
    write_data = 32'h0F0F0F0F;
    cycle();
    Transfer = 1'b0;
    cycle();
    check("chg_access", 32'(dut.r_state), 32'(ACCESS));
    Address    = 12;
    write_data = 32'hFFFFFFFF;
    Wr_Rd      = 1'b0;
    cycle();
    check("chg_idle", 32'(dut.r_state), 32'(IDLE));
    model_mem[9] = 32'h0F0F0F0F;
    cycle();
    check("chg_idle_stays", 32'(dut.r_state), 32'(IDLE));
    xfer(1'b0, 9, '0);
    xfer(1'b0, 12, '0);

    // Reset during ACCESS of a write
    Transfer   = 1'b1;
    Wr_Rd      = 1'b1;
    Address    = 3;
    write_data = 32'hDEADBEEF;
    cycle();
    Transfer = 1'b0;
    cycle();
    check("mid_access", 32'(dut.r_state), 32'(ACCESS));
    PRESETn = 1'b0;
    #1;
    check("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
    check("mid_rst_read_data", read_data, 32'h0);
    clear_model();
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    cycle();
    check("post_rst_idle", 32'(dut.r_state), 32'(IDLE));
    xfer(1'b0, 3, '0);
    xfer(1'b0, 0, '0);

    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
